uart_word_tx: RTL and testbench



---
 rtl/uart_word_tx_pkg.sv | 23 ++
 rtl/uart_word_tx_if.sv | 23 ++
 rtl/uart_word_tx_byte_tx.sv | 96 +++++++++
 rtl/uart_word_tx.sv | 119 +++++++++++
 tb/tb_uart_word_tx.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_word_tx_pkg.sv
// Shared types and frame constants for the buffered 16-bit word UART transmitter.
package uart_word_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO
  } ctrl_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_word_tx_if.sv
// Producer-side write port of uart_word_tx: word, enqueue strobe and FIFO fill status.
interface uart_word_tx_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [15:0]     wr_data;
  logic            wr_req;
  logic [ADDR_W:0] wr_usedw;
  logic            wr_full;

  modport master (
    output wr_data,
    output wr_req,
    input  wr_usedw,
    input  wr_full
  );

  modport slave (
    input  wr_data,
    input  wr_req,
    output wr_usedw,
    output wr_full
  );
endinterface

// File: rtl/uart_word_tx_byte_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
module uart_byte_tx
  import uart_word_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 174
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       tx_req,
  input  logic [7:0] tx_byte,
  output logic       txd,
  output logic       tx_busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_d;
  logic [BAUD_W-1:0] baud, baud_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [7:0]        shift, shift_d;
  logic              bit_end;

  assign bit_end = (baud == BAUD_LAST);

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    unique case (state)
      TX_IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (tx_req) begin
          shift_d = tx_byte;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_d = TX_STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Line level decoded straight from state so an async reset forces txd high at once.
  always_comb begin
    unique case (state)
      TX_START: txd = START_BIT;
      TX_DATA:  txd = shift[0];
      TX_STOP:  txd = STOP_BIT;
      default:  txd = STOP_BIT;
    endcase
  end

  assign tx_busy = (state != TX_IDLE);

endmodule

// File: rtl/uart_word_tx.sv
// Buffered word UART transmitter: 2^ADDR_W-word FIFO drained high byte first into uart_byte_tx.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 174,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic           SYS_CLK,
  input  logic           RST_N,
  uart_word_tx_if.slave  wr_if,
  output logic           txd,
  output logic           tx_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [15:0]       rd_q, word_q;
  logic              wr_en, rd_en, fifo_empty, fifo_full;

  ctrl_state_t       state, state_d;
  logic              seen_busy, seen_busy_d;
  logic              tx_req;
  logic [7:0]        tx_byte;

  assign fifo_full      = (count == FULL_CNT);
  assign fifo_empty     = (count == '0);
  assign wr_en          = wr_if.wr_req && !fifo_full;
  assign wr_if.wr_usedw = count;
  assign wr_if.wr_full  = fifo_full;

  always_ff @(posedge SYS_CLK) begin
    if (wr_en) mem[wr_ptr] <= wr_if.wr_data;
    if (rd_en) rd_q <= mem[rd_ptr];
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_en && !rd_en)      count <= count + (ADDR_W + 1)'(1);
      else if (rd_en && !wr_en) count <= count - (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      seen_busy <= 1'b0;
      word_q    <= '0;
    end else begin
      state     <= state_d;
      seen_busy <= seen_busy_d;
      if (state == LOAD) word_q <= rd_q;
    end
  end

  // WAIT_* leave only after tx_busy has been seen high and then low again.
  always_comb begin
    state_d     = state;
    seen_busy_d = seen_busy;
    rd_en       = 1'b0;
    tx_req      = 1'b0;
    tx_byte     = '0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          rd_en   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = SEND_HI;
      SEND_HI: begin
        tx_byte = word_q[15:8];
        if (!tx_busy) begin
          tx_req      = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy)        seen_busy_d = 1'b1;
        else if (seen_busy) state_d     = SEND_LO;
      end
      SEND_LO: begin
        tx_byte = word_q[7:0];
        if (!tx_busy) begin
          tx_req      = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (tx_busy)        seen_busy_d = 1'b1;
        else if (seen_busy) state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .SYS_CLK (SYS_CLK),
    .RST_N   (RST_N),
    .tx_req  (tx_req),
    .tx_byte (tx_byte),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a line monitor decodes txd frames; tasks compare them to an expected byte queue.
module tb_uart_word_tx;

  localparam int C      = 4;
  localparam int ADDR_W = 8;
  localparam int FRAME  = 10 * C;
  localparam int MAXF   = 2048;

  logic SYS_CLK = 1'b0;
  logic RST_N   = 1'b0;
  logic txd, tx_busy;

  uart_word_tx_if #(.ADDR_W(ADDR_W)) wr_if ();

  uart_word_tx #(
    .CLKS_PER_BIT(C),
    .ADDR_W      (ADDR_W)
  ) dut (
    .SYS_CLK (SYS_CLK),
    .RST_N   (RST_N),
    .wr_if   (wr_if),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] exp_q[$];
  int rd_idx = 0;
  bit chk_gaps = 1'b0;

  // ---------------- line monitor (records observations only) ----------------
  logic [7:0] fr_data [MAXF];
  bit         fr_ok   [MAXF];
  int         fr_gap  [MAXF];
  bit         fr_gv   [MAXF];
  int         n_frames = 0;
  int         stray_busy = 0;

  bit   in_frame = 1'b0, prev_ok = 1'b0, busy_ok, cur_gv;
  int   pos, gap = 0, cur_gap;
  logic samp [FRAME];

  always @(negedge SYS_CLK) begin
    if (!RST_N) begin
      in_frame = 1'b0;
      prev_ok  = 1'b0;
      gap      = 0;
    end else if (!in_frame) begin
      if (!chk_gaps) prev_ok = 1'b0;
      if (txd === 1'b0) begin
        in_frame = 1'b1;
        samp[0]  = 1'b0;
        pos      = 1;
        busy_ok  = (tx_busy === 1'b1);
        cur_gap  = gap;
        cur_gv   = prev_ok && chk_gaps;
      end else begin
        gap++;
        if (tx_busy !== 1'b0) stray_busy++;
      end
    end else begin
      samp[pos] = txd;
      if (tx_busy !== 1'b1) busy_ok = 1'b0;
      pos++;
      if (pos == FRAME) begin
        logic [7:0] d;
        bit ok;
        ok = busy_ok && (samp[0] === 1'b0) && (samp[9*C] === 1'b1);
        for (int b = 0; b < 10; b++)
          for (int k = 0; k < C; k++)
            if (samp[b*C+k] !== samp[b*C]) ok = 1'b0;
        for (int b = 0; b < 8; b++) d[b] = samp[(b+1)*C];
        if (n_frames < MAXF) begin
          fr_data[n_frames] = d;
          fr_ok[n_frames]   = ok;
          fr_gap[n_frames]  = cur_gap;
          fr_gv[n_frames]   = cur_gv;
          n_frames++;
        end
        in_frame = 1'b0;
        gap      = 0;
        prev_ok  = chk_gaps;
      end
    end
  end

  // ---------------- reference model and stimulus helpers ----------------
  function automatic void push_word(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endfunction

  task automatic wait_frames(input int n, output bit ok);
    int budget;
    budget = n * (FRAME + 12) + 300;
    while (n_frames < rd_idx + n && budget > 0) begin
      @(negedge SYS_CLK);
      budget--;
    end
    ok = (n_frames >= rd_idx + n);
  endtask

  task automatic quiesce();
    wr_if.wr_req = 1'b0;
    repeat (10) @(negedge SYS_CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    wr_if.wr_req  = 1'b0;
    wr_if.wr_data = '0;
    repeat (3) @(negedge SYS_CLK);
    RST_N = 1'b1;
    @(negedge SYS_CLK);
    n_checks++; if (txd !== 1'b1) begin n_fails++; $display("FAIL reset_txd: got %b want 1", txd); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_checks++; if (wr_if.wr_usedw !== 9'd0) begin n_fails++; $display("FAIL reset_usedw: got %0d want 0", wr_if.wr_usedw); end
    n_checks++; if (wr_if.wr_full !== 1'b0) begin n_fails++; $display("FAIL reset_full: got %b want 0", wr_if.wr_full); end
  endtask

  task automatic test_single_word();
    bit ok;
    logic [7:0] e;
    wr_if.wr_req = 1'b1; wr_if.wr_data = 16'hA55A; push_word(16'hA55A);
    @(negedge SYS_CLK);
    wr_if.wr_req = 1'b0;
    n_checks++; if (wr_if.wr_usedw !== 9'd1) begin n_fails++; $display("FAIL single_usedw_up: got %0d want 1", wr_if.wr_usedw); end
    @(negedge SYS_CLK);
    n_checks++; if (wr_if.wr_usedw !== 9'd0) begin n_fails++; $display("FAIL single_usedw_down: got %0d want 0", wr_if.wr_usedw); end
    wait_frames(2, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL single_timeout: got %0d frames want %0d", n_frames - rd_idx, 2); end
    for (int i = 0; i < 2 && rd_idx < n_frames; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fr_data[rd_idx] !== e || !fr_ok[rd_idx]) begin
        n_fails++; $display("FAIL single_frame%0d: got %h ok=%b want %h ok=1", i, fr_data[rd_idx], fr_ok[rd_idx], e);
      end
      rd_idx++;
    end
    quiesce();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] e;
    chk_gaps = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      wr_if.wr_req = 1'b1; wr_if.wr_data = 16'(w); push_word(16'(w));
      @(negedge SYS_CLK);
    end
    wr_if.wr_req = 1'b0;
    wait_frames(6, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL b2b_timeout: got %0d frames want %0d", n_frames - rd_idx, 6); end
    for (int i = 0; i < 6 && rd_idx < n_frames; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fr_data[rd_idx] !== e || !fr_ok[rd_idx]) begin
        n_fails++; $display("FAIL b2b_frame%0d: got %h ok=%b want %h ok=1", i, fr_data[rd_idx], fr_ok[rd_idx], e);
      end
      if (fr_gv[rd_idx]) begin
        n_checks++;
        if (fr_gap[rd_idx] < 1 || fr_gap[rd_idx] > 4) begin
          n_fails++; $display("FAIL b2b_gap%0d: got %0d cycles want 1..4", i, fr_gap[rd_idx]);
        end
      end
      rd_idx++;
    end
    chk_gaps = 1'b0;
    quiesce();
  endtask

  task automatic test_random_burst();
    bit ok;
    logic [7:0] e;
    logic [15:0] w;
    for (int n = 0; n < 10; n++) begin
      w = 16'($urandom);
      wr_if.wr_req = 1'b1; wr_if.wr_data = w; push_word(w);
      @(negedge SYS_CLK);
      wr_if.wr_req = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge SYS_CLK);
    end
    wait_frames(20, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL rand_timeout: got %0d frames want %0d", n_frames - rd_idx, 20); end
    for (int i = 0; i < 20 && rd_idx < n_frames; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fr_data[rd_idx] !== e || !fr_ok[rd_idx]) begin
        n_fails++; $display("FAIL rand_frame%0d: got %h ok=%b want %h ok=1", i, fr_data[rd_idx], fr_ok[rd_idx], e);
      end
      rd_idx++;
    end
    quiesce();
  endtask

  // Empty FIFO and idle line: the controller reads the cycle after the first word lands,
  // which coincides with the second write.
  task automatic test_simultaneous();
    bit ok;
    logic [7:0] e;
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    wr_if.wr_req = 1'b1; wr_if.wr_data = a; push_word(a);
    @(negedge SYS_CLK);
    n_checks++; if (wr_if.wr_usedw !== 9'd1) begin n_fails++; $display("FAIL simul_first: got %0d want 1", wr_if.wr_usedw); end
    wr_if.wr_data = b; push_word(b);
    @(negedge SYS_CLK);
    wr_if.wr_req = 1'b0;
    n_checks++; if (wr_if.wr_usedw !== 9'd1) begin n_fails++; $display("FAIL simul_unchanged: got %0d want 1", wr_if.wr_usedw); end
    wait_frames(4, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL simul_timeout: got %0d frames want %0d", n_frames - rd_idx, 4); end
    for (int i = 0; i < 4 && rd_idx < n_frames; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fr_data[rd_idx] !== e || !fr_ok[rd_idx]) begin
        n_fails++; $display("FAIL simul_frame%0d: got %h ok=%b want %h ok=1", i, fr_data[rd_idx], fr_ok[rd_idx], e);
      end
      rd_idx++;
    end
    quiesce();
  endtask

  task automatic test_stream();
    bit ok;
    logic [7:0] e;
    int next = 0, maxu = 0, budget = 30000;
    chk_gaps = 1'b1;
    while (next < 200 && budget > 0) begin
      @(negedge SYS_CLK);
      budget--;
      if (int'(wr_if.wr_usedw) > maxu) maxu = int'(wr_if.wr_usedw);
      if (wr_if.wr_usedw < 9'd128) begin
        wr_if.wr_req = 1'b1; wr_if.wr_data = 16'(next); push_word(16'(next)); next++;
      end else begin
        wr_if.wr_req = 1'b0;
      end
    end
    @(negedge SYS_CLK);
    wr_if.wr_req = 1'b0;
    n_checks++; if (maxu != 128) begin n_fails++; $display("FAIL stream_level: got max %0d want 128", maxu); end
    wait_frames(2 * next, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL stream_timeout: got %0d frames want %0d", n_frames - rd_idx, 2 * next); end
    for (int i = 0; i < 2 * next && rd_idx < n_frames; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fr_data[rd_idx] !== e || !fr_ok[rd_idx]) begin
        n_fails++; $display("FAIL stream_frame%0d: got %h ok=%b want %h ok=1", i, fr_data[rd_idx], fr_ok[rd_idx], e);
      end
      if (fr_gv[rd_idx]) begin
        n_checks++;
        if (fr_gap[rd_idx] < 1 || fr_gap[rd_idx] > 4) begin
          n_fails++; $display("FAIL stream_gap%0d: got %0d cycles want 1..4", i, fr_gap[rd_idx]);
        end
      end
      rd_idx++;
    end
    chk_gaps = 1'b0;
    quiesce();
  endtask

  // Fill until full; the overflow word is offered while a frame is in flight so no read can overlap it.
  task automatic test_fill_full();
    bit ok, done = 1'b0;
    logic [7:0] e;
    int next = 0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge SYS_CLK);
      if (wr_if.wr_full !== 1'b1) begin
        wr_if.wr_req = 1'b1; wr_if.wr_data = 16'(next); push_word(16'(next)); next++;
      end else if (tx_busy === 1'b1) begin
        n_checks++; if (wr_if.wr_usedw !== 9'd256) begin n_fails++; $display("FAIL full_level: got %0d want 256", wr_if.wr_usedw); end
        wr_if.wr_req = 1'b1; wr_if.wr_data = 16'hFFFF; done = 1'b1;
      end else begin
        wr_if.wr_req = 1'b0;
      end
    end
    @(negedge SYS_CLK);
    wr_if.wr_req = 1'b0;
    n_checks++; if (!done) begin n_fails++; $display("FAIL full_reached: got never want full after %0d writes", next); end
    n_checks++; if (wr_if.wr_usedw !== 9'd256) begin n_fails++; $display("FAIL full_drop_count: got %0d want 256", wr_if.wr_usedw); end
    n_checks++; if (wr_if.wr_full !== 1'b1) begin n_fails++; $display("FAIL full_flag: got %b want 1", wr_if.wr_full); end
    wait_frames(2 * next, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL full_timeout: got %0d frames want %0d", n_frames - rd_idx, 2 * next); end
    for (int i = 0; i < 2 * next && rd_idx < n_frames; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fr_data[rd_idx] !== e || !fr_ok[rd_idx]) begin
        n_fails++; $display("FAIL full_frame%0d: got %h ok=%b want %h ok=1", i, fr_data[rd_idx], fr_ok[rd_idx], e);
      end
      rd_idx++;
    end
    repeat (2 * (FRAME + 12)) @(negedge SYS_CLK);
    n_checks++; if (n_frames != rd_idx) begin n_fails++; $display("FAIL full_no_extra: got %0d extra frames want 0", n_frames - rd_idx); end
    quiesce();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [7:0] e;
    logic [15:0] w;
    int low_cnt = 0, budget = 40;
    for (int n = 0; n < 3; n++) begin
      wr_if.wr_req = 1'b1; wr_if.wr_data = 16'($urandom);
      @(negedge SYS_CLK);
    end
    wr_if.wr_req = 1'b0;
    while (tx_busy !== 1'b1 && budget > 0) begin @(negedge SYS_CLK); budget--; end
    n_checks++; if (tx_busy !== 1'b1) begin n_fails++; $display("FAIL rst_frame_start: got busy=%b want 1", tx_busy); end
    repeat (3 * C + 1) @(negedge SYS_CLK);
    #2 RST_N = 1'b0;
    #1;
    n_checks++; if (txd !== 1'b1) begin n_fails++; $display("FAIL rst_mid_txd: got %b want 1", txd); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fails++; $display("FAIL rst_mid_busy: got %b want 0", tx_busy); end
    n_checks++; if (wr_if.wr_usedw !== 9'd0) begin n_fails++; $display("FAIL rst_mid_usedw: got %0d want 0", wr_if.wr_usedw); end
    repeat (3) @(negedge SYS_CLK);
    RST_N = 1'b1;
    rd_idx = n_frames;
    repeat (30 * C) begin
      @(negedge SYS_CLK);
      if (txd !== 1'b1) low_cnt++;
    end
    n_checks++; if (low_cnt != 0 || n_frames != rd_idx) begin
      n_fails++; $display("FAIL rst_no_frame: got %0d low cycles %0d frames want 0 0", low_cnt, n_frames - rd_idx);
    end
    w = 16'($urandom);
    wr_if.wr_req = 1'b1; wr_if.wr_data = w; push_word(w);
    @(negedge SYS_CLK);
    wr_if.wr_req = 1'b0;
    wait_frames(2, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL rst_after_timeout: got %0d frames want %0d", n_frames - rd_idx, 2); end
    for (int i = 0; i < 2 && rd_idx < n_frames; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (fr_data[rd_idx] !== e || !fr_ok[rd_idx]) begin
        n_fails++; $display("FAIL rst_after_frame%0d: got %h ok=%b want %h ok=1", i, fr_data[rd_idx], fr_ok[rd_idx], e);
      end
      rd_idx++;
    end
    quiesce();
  endtask

  initial begin
    wr_if.wr_req  = 1'b0;
    wr_if.wr_data = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random_burst();
    test_simultaneous();
    test_stream();
    test_fill_full();
    test_reset_mid_frame();
    n_checks++;
    if (stray_busy != 0) begin n_fails++; $display("FAIL busy_outside_frame: got %0d cycles want 0", stray_busy); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
